// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and flag bundle shared by the alu datapath.
package alu_pkg;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEGA = 2'b10;
    localparam logic [1:0] OP_NEGB = 2'b11;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    typedef struct packed {
        logic z;
        logic c;
        logic s;
    } flags_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational result/flag generation around one shared WIDTH+1 adder.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             arit,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r,
    output flags_t           flags
);
    logic [WIDTH-1:0] x, y, lg;
    logic             cin;
    logic [WIDTH:0]   sum;

    // Subtract and both negations are x + y + 1 with an inverted operand.
    assign x   = op == OP_NEGA ? ~a : op == OP_NEGB ? '0 : a;
    assign y   = op == OP_ADD ? b : op == OP_NEGA ? '0 : ~b;
    assign cin = op != OP_ADD;
    assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    assign lg = op == OP_AND ? a & b :
                op == OP_OR  ? a | b :
                op == OP_XOR ? a ^ b : ~a;

    assign r       = arit ? sum[WIDTH-1:0] : lg;
    assign flags.z = r == '0;
    assign flags.c = arit & sum[WIDTH];
    assign flags.s = arit & sum[WIDTH-1];
endmodule

// File: rtl/alu.sv
// alu: registered arithmetic/logic unit with zero/carry/sign flags and valid qualifier.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             arit,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             c,
    output logic             s,
    output logic             out_valid
);
    logic [WIDTH-1:0] r_d, r_q;
    flags_t           f_d, f_q;
    logic             v_q;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a    (a),
        .b    (b),
        .arit (arit),
        .op   (op),
        .r    (r_d),
        .flags(f_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            f_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= in_valid;
            if (in_valid) begin
                r_q <= r_d;
                f_q <= f_d;
            end
        end
    end

    assign r         = r_q;
    assign z         = f_q.z;
    assign c         = f_q.c;
    assign s         = f_q.s;
    assign out_valid = v_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors against hand-computed results for the 4-bit alu.
module tb_alu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       arit = 1'b0;
    logic [1:0] op = '0;
    logic [3:0] r;
    logic       z, c, s, out_valid;
    int         n_vec = 0, n_bad = 0;

    alu #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .arit     (arit),
        .op       (op),
        .r        (r),
        .z        (z),
        .c        (c),
        .s        (s),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Flags are compared as {z,c,s}; result and valid separately.
    task automatic vec(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                       input logic ari, input logic [1:0] opi,
                       input logic [3:0] er, input logic [2:0] ezcs);
        @(negedge clk);
        a = ai; b = bi; arit = ari; op = opi; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".r"}, {4'b0, r}, {4'b0, er});
        check({tag, ".zcs"}, {5'b0, z, c, s}, {5'b0, ezcs});
        check({tag, ".vld"}, {7'b0, out_valid}, 8'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst", {1'b0, out_valid, s, c, z, r[2:0]}, 8'd0);
        check("rst.r", {4'b0, r}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vec("add",     4'b1010, 4'b1110, 1'b1, 2'b00, 4'b1000, 3'b011);
        vec("add0",    4'b1010, 4'b0110, 1'b1, 2'b00, 4'b0000, 3'b110);
        vec("subeq",   4'b1010, 4'b1010, 1'b1, 2'b01, 4'b0000, 3'b110);
        vec("negb",    4'b1011, 4'b1110, 1'b1, 2'b11, 4'b0010, 3'b000);
        vec("nega",    4'b1110, 4'b0000, 1'b1, 2'b10, 4'b0010, 3'b000);
        vec("nega0",   4'b0000, 4'b0101, 1'b1, 2'b10, 4'b0000, 3'b110);
        vec("and",     4'b1010, 4'b1100, 1'b0, 2'b00, 4'b1000, 3'b000);
        vec("or",      4'b1010, 4'b1100, 1'b0, 2'b01, 4'b1110, 3'b000);
        vec("xor",     4'b1010, 4'b1100, 1'b0, 2'b10, 4'b0110, 3'b000);
        vec("nota",    4'b1010, 4'b1100, 1'b0, 2'b11, 4'b0101, 3'b000);
        vec("and0",    4'b0101, 4'b1010, 1'b0, 2'b00, 4'b0000, 3'b100);
        vec("subbor",  4'b0011, 4'b0101, 1'b1, 2'b01, 4'b1110, 3'b001);
        @(negedge clk);
        in_valid = 1'b0;
        a = 4'b1111; b = 4'b1111; arit = 1'b1; op = 2'b00;
        @(posedge clk);
        #1;
        check("hold.r", {4'b0, r}, 8'b0000_1110);
        check("hold.zcs", {5'b0, z, c, s}, 8'b0000_0001);
        check("hold.vld", {7'b0, out_valid}, 8'd0);
        vec("addff",   4'b1111, 4'b1111, 1'b1, 2'b00, 4'b1110, 3'b011);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.r", {4'b0, r}, 8'd0);
        check("arst.flg", {4'b0, out_valid, z, c, s}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vec("post",    4'b0011, 4'b0101, 1'b1, 2'b01, 4'b1110, 3'b001);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
